// File: rtl/rgb_video_capture.sv
// rgb_video_capture: RGB888 stream to RGB565 writer with resolution tracking and stable-frame gating
module rgb_video_capture #(
  parameter int WAIT_FRAMES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cap_en,
  input  logic        in_vs,
  input  logic        in_hs,
  input  logic        in_de,
  input  logic [23:0] in_rgb,
  output logic        out_wr_en,
  output logic [15:0] out_data,
  output logic        out_frame_start,
  output logic        out_frame_done,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        frame_valid,
  output logic        fmt_err
);
  localparam int SW = $clog2(WAIT_FRAMES + 2);
  localparam logic [SW-1:0] WF = SW'(WAIT_FRAMES);
  localparam logic [1:0] IDLE = 2'd0, SYNC = 2'd1, SKIP = 2'd2, CAPT = 2'd3;
  localparam logic [10:0] XMAX = 11'd2047;
  logic vs1, vs2, hs1, de1, de2, fs, le, match, unused_hs;
  logic [23:0] rgb1;
  logic [10:0] x, y, last_w;
  logic [SW-1:0] stable, stable_nxt;
  logic [1:0] state, nxt;
  assign unused_hs = hs1;
  assign fs = vs1 & ~vs2;
  // a line end coinciding with a frame start is absorbed by the frame start
  assign le = de2 & ~de1 & ~fs;
  assign match = last_w == h_disp && y == v_disp;
  assign stable_nxt = !match ? '0 : stable == WF ? WF : stable + 1'b1;
  assign frame_valid = state == CAPT;
  // CAPTURE only reacts at frame boundaries so a running frame always completes
  assign nxt = state == IDLE ? (cap_en ? SYNC : IDLE)
             : state == CAPT ? (!fs ? CAPT : !cap_en ? IDLE : match ? CAPT : SKIP)
             : !cap_en ? IDLE
             : !fs ? state
             : state == SYNC ? SKIP
             : (match && stable_nxt == WF) ? CAPT : SKIP;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      {vs1, vs2, hs1, de1, de2, rgb1} <= '0;
      {x, y, last_w, stable, state} <= '0;
      {out_wr_en, out_data, out_frame_start, out_frame_done, fmt_err} <= '0;
      {pixel_xpos, pixel_ypos, h_disp, v_disp} <= '0;
    end else begin
      vs1 <= in_vs;
      hs1 <= in_hs;
      de1 <= in_de;
      rgb1 <= in_rgb;
      vs2 <= vs1;
      de2 <= de1;
      x <= fs ? {10'd0, de1} : le ? '0 : (de1 && x != XMAX) ? x + 11'd1 : x;
      y <= fs ? '0 : (le && y != XMAX) ? y + 11'd1 : y;
      last_w <= fs ? '0 : le ? x : last_w;
      pixel_xpos <= fs ? '0 : x;
      pixel_ypos <= fs ? '0 : y;
      out_wr_en <= de1 && nxt == CAPT;
      out_data <= {rgb1[23:19], rgb1[15:10], rgb1[7:3]};
      out_frame_start <= fs && nxt == CAPT;
      out_frame_done <= fs && state == CAPT;
      fmt_err <= fs && !match;
      stable <= fs ? stable_nxt : stable;
      h_disp <= (fs && !match) ? last_w : h_disp;
      v_disp <= (fs && !match) ? y : v_disp;
      state <= nxt;
    end
endmodule

// File: tb/tb_rgb_video_capture.sv
// tb_rgb_video_capture: frame-level behavioural model checked against the capture block every cycle
module tb_rgb_video_capture;
  localparam int W = 4;
  localparam int IDLE = 0, SYNC = 1, SKIP = 2, CAPT = 3;
  logic sys_clk = 0, sys_rst_n = 0, cap_en = 0, in_vs = 0, in_hs = 0, in_de = 0;
  logic [23:0] in_rgb = 0;
  logic out_wr_en, out_frame_start, out_frame_done, frame_valid, fmt_err;
  logic [15:0] out_data;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  rgb_video_capture #(.WAIT_FRAMES(W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cap_en(cap_en), .in_vs(in_vs), .in_hs(in_hs),
    .in_de(in_de), .in_rgb(in_rgb), .out_wr_en(out_wr_en), .out_data(out_data),
    .out_frame_start(out_frame_start), .out_frame_done(out_frame_done), .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos), .h_disp(h_disp), .v_disp(v_disp), .frame_valid(frame_valid),
    .fmt_err(fmt_err));
  always #5 sys_clk = ~sys_clk;
  typedef struct packed {
    logic vld, wr, fst, fdn, fer, fv;
    logic [15:0] d;
    logic [10:0] x, y, h, v;
  } exp_t;
  exp_t p1 = '0, p2 = '0;
  int errors = 0, checks = 0, wr_cnt = 0, fe_cnt = 0, max_x = 0, wr0 = 0, fe0 = 0;
  int m_state = IDLE, m_h = 0, m_v = 0, m_stable = 0, m_pw = 0, m_ph = 0;
  logic last_vs = 0, got_first = 0;
  logic [15:0] first_d = 0;
  logic [10:0] first_x = 0, first_y = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [15:0] pack(logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction
  always @(negedge sys_clk) if (sys_rst_n) begin
    if (out_wr_en === 1'b1) begin
      wr_cnt++;
      if (int'(pixel_xpos) > max_x) max_x = int'(pixel_xpos);
      if (!got_first) begin
        got_first = 1;
        first_d = out_data;
        first_x = pixel_xpos;
        first_y = pixel_ypos;
      end
    end
    if (fmt_err === 1'b1) fe_cnt++;
    if (p2.vld) begin
      chk("wr_en", out_wr_en, p2.wr);
      chk("frame_start", out_frame_start, p2.fst);
      chk("frame_done", out_frame_done, p2.fdn);
      chk("fmt_err", fmt_err, p2.fer);
      chk("frame_valid", frame_valid, p2.fv);
      chk("h_disp", h_disp, p2.h);
      chk("v_disp", v_disp, p2.v);
      if (p2.wr) begin
        chk("out_data", out_data, p2.d);
        chk("xpos", pixel_xpos, p2.x);
        chk("ypos", pixel_ypos, p2.y);
      end
    end
  end
  task automatic m_fs(inout exp_t e);
    logic match;
    match = m_pw == m_h && m_ph == m_v;
    e.fdn = m_state == CAPT;
    e.fer = !match;
    if (!match) begin
      m_h = m_pw;
      m_v = m_ph;
      m_stable = 0;
    end else if (m_stable < W) m_stable++;
    if (m_state == SYNC) m_state = SKIP;
    else if (m_state == SKIP) m_state = (match && m_stable == W) ? CAPT : SKIP;
    else if (m_state == CAPT) m_state = !cap_en ? IDLE : match ? CAPT : SKIP;
    e.fst = m_state == CAPT;
    m_pw = 0;
    m_ph = 0;
  endtask
  task automatic cyc(logic vs, logic hs, logic de, logic [23:0] rgb, int lx = 0, int ly = 0);
    exp_t e;
    e = '0;
    in_vs = vs;
    in_hs = hs;
    in_de = de;
    in_rgb = rgb;
    e.vld = 1;
    if (vs && !last_vs) m_fs(e);
    last_vs = vs;
    e.fv = m_state == CAPT;
    e.h = 11'(m_h);
    e.v = 11'(m_v);
    if (de) begin
      e.wr = m_state == CAPT;
      e.d = pack(rgb);
      e.x = 11'(lx > 2047 ? 2047 : lx);
      e.y = 11'(ly > 2047 ? 2047 : ly);
    end
    @(posedge sys_clk);
    p2 = p1;
    p1 = e;
    #1;
  endtask
  task automatic set_cap(logic v);
    cap_en = v;
    if (!v && (m_state == SYNC || m_state == SKIP)) m_state = IDLE;
    if (v && m_state == IDLE) m_state = SYNC;
  endtask
  task automatic rst_zero(string tag);
    chk({tag, "_wr"}, out_wr_en, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_fv"}, frame_valid, 0);
    chk({tag, "_h"}, h_disp, 0);
    chk({tag, "_xpos"}, pixel_xpos, 0);
    chk({tag, "_done"}, out_frame_done, 0);
  endtask
  task automatic do_reset();
    sys_rst_n = 0;
    {in_vs, in_hs, in_de, in_rgb} = '0;
    p1 = '0;
    p2 = '0;
    #1;
    rst_zero("async_rst");
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_hold_done", out_frame_done, 0);
    sys_rst_n = 1;
    m_state = cap_en ? SYNC : IDLE;
    {m_h, m_v, m_stable, m_pw, m_ph} = '0;
    last_vs = 0;
  endtask
  task automatic frame(int w, int h, int drop = -1, int rst_l = -1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int l = 0; l < h; l++) begin
      if (l == drop) set_cap(0);
      for (int i = 0; i < w; i++) begin
        if (l == rst_l && i == w / 2) begin
          do_reset();
          return;
        end
        cyc(0, 0, 1, (l == 0 && i == 0) ? 24'hFF8040 : 24'($urandom), i, l);
      end
      m_pw = w > 2047 ? 2047 : w;
      m_ph = l + 1;
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0);
  endtask
  initial begin
    #1;
    rst_zero("reset");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1;
    repeat (3) cyc(0, 0, 0, 0);
    set_cap(1);
    repeat (2) cyc(0, 0, 0, 0);
    repeat (5) frame(8, 4);
    chk("skip_frames_wr", wr_cnt, 0);
    chk("skip_frames_fv", frame_valid, 0);
    frame(8, 4);
    chk("frame6_wr", wr_cnt, 32);
    chk("frame6_fv", frame_valid, 1);
    chk("frame6_h", h_disp, 8);
    chk("frame6_v", v_disp, 4);
    chk("first_data", first_d, 16'hFC08);
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    repeat (2) frame(8, 4);
    fe0 = fe_cnt;
    repeat (5) frame(6, 4);
    frame(6, 4, 2);
    frame(6, 4);
    chk("fmt_err_pulses", fe_cnt - fe0, 1);
    chk("fmt_h", h_disp, 6);
    chk("drop_wr", wr_cnt, 144);
    chk("drop_fv", frame_valid, 0);
    frame(6, 4);
    chk("idle_wr", wr_cnt, 144);
    set_cap(1);
    repeat (2) cyc(0, 0, 0, 0);
    frame(6, 4);
    frame(6, 4, -1, 1);
    repeat (3) cyc(0, 0, 0, 0);
    wr0 = wr_cnt;
    repeat (6) frame(2100, 1);
    chk("long_wr", wr_cnt - wr0, 2100);
    chk("long_max_x", max_x, 2047);
    chk("long_h", h_disp, 2047);
    chk("long_v", v_disp, 1);
    frame(1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
